// File: rtl/binary_frame_reader_pkg.sv
// binary_frame_reader_pkg
// Shared definitions for the binary frame reader: default geometry and buffer
// widths, the buffer read/write encoding, the reader FSM state type and the
// header byte helper.
// Optional build macro: FRAME_HEADER_EN adds the header state to the FSM.
package binary_frame_reader_pkg;

    localparam int DEF_A_WIDTH = 17;
    localparam int DEF_D_WIDTH = 8;
    localparam int DEF_ROW     = 320;
    localparam int DEF_COL     = 240;
    localparam int DEF_RD_LAT  = 2;

    // Buffer control encoding: RW=0 read, RW=1 write. This block only reads.
    localparam logic RW_READ = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef FRAME_HEADER_EN
        S_HDR,
`endif
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_EMIT,
        S_FINISH
    } state_t;

    // Header byte idx of 0..3: COL low, COL high, ROW low, ROW high.
    function automatic logic [7:0] header_byte(input logic [1:0]  idx,
                                               input logic [15:0] rows,
                                               input logic [15:0] cols);
        logic [7:0] b;
        case (idx)
            2'd0:    b = cols[7:0];
            2'd1:    b = cols[15:8];
            2'd2:    b = rows[7:0];
            default: b = rows[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/binary_frame_reader_if.sv
// binary_frame_reader_if
// Byte stream between the frame reader and its sink (host link / UART / DMA).
// Signals:
//   M_Data   packed byte
//   M_Valid  M_Data valid
//   M_Ready  sink accepts when M_Valid & M_Ready at a rising edge
//   M_Last   high with the final byte of the frame
// Modports: master (reader side), slave (sink side).
interface binary_frame_reader_if;
    logic [7:0] M_Data;
    logic       M_Valid;
    logic       M_Ready;
    logic       M_Last;

    modport master (output M_Data, output M_Valid, output M_Last, input M_Ready);
    modport slave  (input  M_Data, input  M_Valid, input  M_Last, output M_Ready);
endinterface

// File: rtl/binary_frame_reader_bit_packer.sv
// binary_frame_reader_bit_packer
// 8-bit packing register with a 3-bit fill count. Each shift writes bit_in
// into bit[count], so the first pixel lands in the LSB and an incomplete byte
// keeps zeros in its high bits.
// Ports:
//   Clk, Rst   clock, asynchronous active-high reset
//   clr        empty the register (priority over shift_en)
//   shift_en   store bit_in at the current count and advance it
//   bit_in     pixel bit
//   full       this shift writes the eighth bit
//   byte_out   register contents including the bit being shifted this cycle
module binary_frame_reader_bit_packer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic       full,
    output logic [7:0] byte_out
);

    logic [7:0] data_q;
    logic [2:0] cnt_q;

    // byte_out already contains the incoming bit so the caller can register a
    // finished byte on the same edge that shifts its last bit in.
    always_comb begin
        // NOTE: byte_out gets its full default before the conditional write;
        // without it the partial assignment would infer a latch.
        byte_out = data_q;
        if (shift_en) begin
            byte_out[cnt_q] = bit_in;
        end
    end

    assign full = shift_en && (cnt_q == 3'd7);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees pre-edge values regardless of statement order.
            data_q <= byte_out;
            cnt_q  <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/binary_frame_reader.sv
// binary_frame_reader
// Drains the binary (0/255) frame buffer in raster order, packs 8 pixels per
// byte (LSB = lowest address, partial final byte zero-padded in the high bits)
// and streams the bytes on a valid/ready byte port. Each pixel costs an
// issue cycle, RD_LAT-1 wait cycles and a capture cycle; each byte adds one
// emit cycle. All outputs are registered.
// Optional build macro: FRAME_HEADER_EN -- the frame is preceded by 4 header
// bytes COL[7:0], COL[15:8], ROW[7:0], ROW[15:8] (never flagged M_Last).
// Ports:
//   Clk, Rst   clock, asynchronous active-high reset
//   Go         start pulse, sampled only while idle
//   R_Addr     buffer read address = Y*COL+X
//   R_En       one-cycle read enable per pixel
//   R_RW       always 0 (read)
//   R_Data     buffer read data; any nonzero value packs as 1
//   m          byte stream master: M_Data, M_Valid, M_Last out; M_Ready in
//   Busy       high from the cycle after Go is accepted until Done
//   Done       one-cycle pulse after the final byte is accepted
module binary_frame_reader
    import binary_frame_reader_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int ROW     = DEF_ROW,
    parameter int COL     = DEF_COL,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Go,
    output logic [A_WIDTH-1:0]     R_Addr,
    output logic                   R_En,
    output logic                   R_RW,
    input  logic [D_WIDTH-1:0]     R_Data,
    binary_frame_reader_if.master  m,
    output logic                   Busy,
    output logic                   Done
);

    localparam logic [A_WIDTH-1:0] LAST_PIX = A_WIDTH'(ROW * COL - 1);

    state_t             state;
    logic [A_WIDTH-1:0] pix;
    logic [7:0]         lat_cnt;
`ifdef FRAME_HEADER_EN
    logic [1:0]         hdr_idx;
`endif

    logic       pk_shift;
    logic       pk_full;
    logic [7:0] pk_byte;
    logic       last_pix;
    logic       emit_now;

    assign pk_shift = (state == S_CAPT);
    assign last_pix = (pix == LAST_PIX);
    // Byte completes on the eighth capture or on the frame's final pixel.
    assign emit_now = pk_shift && (pk_full || last_pix);

    binary_frame_reader_bit_packer u_bit_packer (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr      (emit_now),
        .shift_en (pk_shift),
        .bit_in   (|R_Data),
        .full     (pk_full),
        .byte_out (pk_byte)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            pix       <= '0;
            lat_cnt   <= '0;
            R_Addr    <= '0;
            R_En      <= 1'b0;
            R_RW      <= RW_READ;
            m.M_Data  <= '0;
            m.M_Valid <= 1'b0;
            m.M_Last  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef FRAME_HEADER_EN
            hdr_idx   <= '0;
`endif
        end else begin
            // Read port and Done are pulses: idle values unless a state below
            // drives them this cycle.
            R_En   <= 1'b0;
            R_Addr <= '0;
            R_RW   <= RW_READ;
            Done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Go) begin
                        Busy <= 1'b1;
                        pix  <= '0;
`ifdef FRAME_HEADER_EN
                        hdr_idx   <= 2'd0;
                        m.M_Data  <= header_byte(2'd0, 16'(ROW), 16'(COL));
                        m.M_Valid <= 1'b1;
                        m.M_Last  <= 1'b0;
                        state     <= S_HDR;
`else
                        state <= S_ISSUE;
`endif
                    end
                end
`ifdef FRAME_HEADER_EN
                S_HDR: begin
                    if (m.M_Ready) begin
                        if (hdr_idx == 2'd3) begin
                            m.M_Valid <= 1'b0;
                            state     <= S_ISSUE;
                        end else begin
                            hdr_idx  <= hdr_idx + 2'd1;
                            m.M_Data <= header_byte(hdr_idx + 2'd1, 16'(ROW), 16'(COL));
                        end
                    end
                end
`endif
                S_ISSUE: begin
                    R_Addr  <= pix;
                    R_En    <= 1'b1;
                    lat_cnt <= '0;
                    state   <= (RD_LAT > 1) ? S_WAIT : S_CAPT;
                end
                S_WAIT: begin
                    // RD_LAT-1 wait cycles between issue and capture.
                    if (lat_cnt == 8'(RD_LAT - 2)) begin
                        state <= S_CAPT;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                S_CAPT: begin
                    pix <= pix + A_WIDTH'(1);
                    if (emit_now) begin
                        m.M_Data  <= pk_byte;
                        m.M_Valid <= 1'b1;
                        m.M_Last  <= last_pix;
                        state     <= S_EMIT;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_EMIT: begin
                    if (m.M_Ready) begin
                        m.M_Valid <= 1'b0;
                        m.M_Last  <= 1'b0;
                        state     <= m.M_Last ? S_FINISH : S_ISSUE;
                    end
                end
                S_FINISH: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_frame_reader.sv
// tb_binary_frame_reader
// Self-checking bench for binary_frame_reader. Two instances: a 10x24 frame
// (240 px, 30 bytes) and a 3x3 frame (9 px, zero-padded last byte). Each has
// a one-cycle synchronous buffer model that returns random garbage whenever
// no read was issued the previous cycle. Expected byte streams are computed
// directly from buffer contents by pixel arithmetic.
// Build macro FRAME_HEADER_EN, when defined for the design, must also be
// defined here so the expected stream includes the 4 header bytes.
`timescale 1ns/1ps
module tb_binary_frame_reader;

    localparam int ROW0   = 10;
    localparam int COL0   = 24;
    localparam int ROW1   = 3;
    localparam int COL1   = 3;
    localparam int BUDGET = 4000;

    typedef struct packed {
        logic [16:0] raddr;
        logic        ren;
        logic        rrw;
        logic [7:0]  data;
        logic        valid;
        logic        last;
        logic        busy;
        logic        done;
    } obs_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        go0 = 1'b0, go1 = 1'b0;
    logic        rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0]  r_data0 = 8'h00, r_data1 = 8'h00;
    logic [16:0] raddr0, raddr1;
    logic        ren0, ren1, rrw0, rrw1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [2][256];
    logic [7:0] got_data [$];
    logic       got_last [$];
    logic [7:0] exp_data [$];
    logic       exp_last [$];
    int         addr_log [$];
    int         rw_bad = 0;

    binary_frame_reader_if if0 ();
    binary_frame_reader_if if1 ();
    assign if0.M_Ready = rdy0;
    assign if1.M_Ready = rdy1;

    binary_frame_reader #(.ROW(ROW0), .COL(COL0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Go(go0), .R_Addr(raddr0), .R_En(ren0), .R_RW(rrw0),
        .R_Data(r_data0), .m(if0), .Busy(busy0), .Done(done0)
    );

    binary_frame_reader #(.ROW(ROW1), .COL(COL1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Go(go1), .R_Addr(raddr1), .R_En(ren1), .R_RW(rrw1),
        .R_Data(r_data1), .m(if1), .Busy(busy1), .Done(done1)
    );

    always #5 Clk = ~Clk;

    // Buffer models: data valid only in the cycle after R_En, garbage otherwise.
    always @(posedge Clk) begin
        if (ren0) begin
            r_data0 <= mem[0][raddr0[7:0]];
            addr_log.push_back(int'(raddr0));
            if (rrw0 !== 1'b0) rw_bad++;
        end else begin
            r_data0 <= 8'($urandom);
        end
        if (ren1) begin
            r_data1 <= mem[1][raddr1[7:0]];
            addr_log.push_back(int'(raddr1));
            if (rrw1 !== 1'b0) rw_bad++;
        end else begin
            r_data1 <= 8'($urandom);
        end
    end

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 0) o = '{raddr0, ren0, rrw0, if0.M_Data, if0.M_Valid, if0.M_Last, busy0, done0};
        else          o = '{raddr1, ren1, rrw1, if1.M_Data, if1.M_Valid, if1.M_Last, busy1, done1};
        return o;
    endfunction

    task automatic set_go(input int sel, input logic v);
        if (sel == 0) go0 = v; else go1 = v;
    endtask

    task automatic set_rdy(input int sel, input logic v);
        if (sel == 0) rdy0 = v; else rdy1 = v;
    endtask

    function automatic int npix(input int sel);
        return (sel == 0) ? ROW0 * COL0 : ROW1 * COL1;
    endfunction

    // Reference model: optional header, then ceil(N/8) bytes where bit j of
    // byte b is 1 when pixel 8b+j exists and is nonzero; last flag on final byte.
    function automatic void build_expected(input int sel);
        int rows, cols, n;
        logic [7:0] v;
        rows = (sel == 0) ? ROW0 : ROW1;
        cols = (sel == 0) ? COL0 : COL1;
        n    = rows * cols;
        exp_data.delete();
        exp_last.delete();
`ifdef FRAME_HEADER_EN
        exp_data.push_back(8'(cols));
        exp_data.push_back(8'(cols >> 8));
        exp_data.push_back(8'(rows));
        exp_data.push_back(8'(rows >> 8));
        repeat (4) exp_last.push_back(1'b0);
`endif
        for (int b = 0; b * 8 < n; b++) begin
            v = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < n && mem[sel][b * 8 + j] != 8'h00) v[j] = 1'b1;
            end
            exp_data.push_back(v);
            exp_last.push_back((b + 1) * 8 >= n);
        end
    endfunction

    // Start a frame and act as the sink until Done, the byte limit
    // stop_after (>=0) or the cycle budget. Bytes are recorded at the negedge
    // before the posedge that accepts them. While a byte is stalled the next
    // cycle must present the same byte. Go is raised again while go_again_at
    // bytes have been accepted (>=0) to probe Go-while-busy.
    task automatic run_frame(input int sel, input int ready_pct, input int stop_after,
                             input int go_again_at, output bit done_seen);
        obs_t o, prev;
        bit   stall;
        logic r;
        stall = 1'b0;
        prev  = '0;
        done_seen = 1'b0;
        got_data.delete();
        got_last.delete();
        addr_log.delete();
        rw_bad = 0;
        @(negedge Clk);
        set_go(sel, 1'b1);
        @(negedge Clk);
        set_go(sel, 1'b0);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            o = observe(sel);
            if (stall) begin
                checks++;
                if (o.valid !== 1'b1 || o.data !== prev.data || o.last !== prev.last) begin
                    errors++;
                    $display("FAIL hold_stable sel=%0d after byte %0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             sel, got_data.size(), o.valid, o.data, o.last, prev.data, prev.last);
                end
            end
            if (o.done) begin
                done_seen = 1'b1;
                set_rdy(sel, 1'b0);
                set_go(sel, 1'b0);
                return;
            end
            r = ($urandom_range(99) < ready_pct);
            set_rdy(sel, r);
            if (o.valid && r) begin
                got_data.push_back(o.data);
                got_last.push_back(o.last);
            end
            stall = o.valid && !r;
            prev  = o;
            set_go(sel, go_again_at >= 0 && got_data.size() == go_again_at);
            if (stop_after >= 0 && got_data.size() >= stop_after) return;
            @(negedge Clk);
        end
        set_go(sel, 1'b0);
    endtask

    task automatic test_reset();
        obs_t o;
        #1 Rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_async sel=%0d: outputs %h, required all zero", s, o);
            end
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_idle sel=%0d: outputs %h, required all zero without Go", s, o);
            end
        end
    endtask

    task automatic test_all_ones();
        bit done;
        obs_t o;
        for (int k = 0; k < 256; k++) mem[0][k] = (k < npix(0)) ? 8'hFF : 8'($urandom);
        build_expected(0);
        run_frame(0, 100, -1, -1, done);
        checks++;
        if (!done) begin errors++; $display("FAIL all_ones done: no Done within %0d cycles", BUDGET); end
        o = observe(0);
        checks++;
        if (o.busy !== 1'b0) begin errors++; $display("FAIL all_ones busy_at_done: got %b, required 0", o.busy); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL all_ones byte_count: got %0d, required %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL all_ones byte[%0d]: got %h last=%b, required %h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        @(negedge Clk);
        o = observe(0);
        checks++;
        if (o.done !== 1'b0) begin errors++; $display("FAIL all_ones done_pulse: Done still %b a cycle later, required 0", o.done); end
    endtask

    task automatic test_alternating();
        bit done;
        int bad_at;
        for (int k = 0; k < 256; k++) mem[0][k] = (k % 2 == 1) ? 8'hFF : 8'h00;
        build_expected(0);
        run_frame(0, 100, -1, -1, done);
        checks++;
        if (!done) begin errors++; $display("FAIL alternating done: no Done within %0d cycles", BUDGET); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL alternating byte_count: got %0d, required %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL alternating byte[%0d]: got %h last=%b, required %h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        bad_at = -1;
        for (int i = 0; i < addr_log.size(); i++) if (bad_at < 0 && addr_log[i] != i) bad_at = i;
        checks++;
        if (addr_log.size() != npix(0) || bad_at >= 0) begin
            errors++;
            $display("FAIL alternating addr_seq: %0d reads, first wrong index %0d, required %0d reads 0..%0d",
                     addr_log.size(), bad_at, npix(0), npix(0) - 1);
        end
        checks++;
        if (rw_bad != 0) begin errors++; $display("FAIL alternating r_rw: %0d reads with R_RW=1, required 0", rw_bad); end
    endtask

    task automatic test_backpressure();
        bit done;
        // Odd pixels carry arbitrary nonzero values: any nonzero packs as 1.
        for (int k = 0; k < 256; k++) mem[0][k] = (k % 2 == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
        build_expected(0);
        run_frame(0, 50, -1, -1, done);
        checks++;
        if (!done) begin errors++; $display("FAIL backpressure done: no Done within %0d cycles", BUDGET); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL backpressure byte_count: got %0d, required %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL backpressure byte[%0d]: got %h last=%b, required %h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random_data();
        bit done;
        for (int k = 0; k < 256; k++)
            mem[0][k] = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        build_expected(0);
        run_frame(0, 70, -1, -1, done);
        checks++;
        if (!done) begin errors++; $display("FAIL random_data done: no Done within %0d cycles", BUDGET); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL random_data byte_count: got %0d, required %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL random_data byte[%0d]: got %h last=%b, required %h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_small_frame();
        bit done;
        obs_t o;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 256; k++)
                mem[1][k] = (pass == 0) ? 8'hFF : 8'($urandom_range(1) * $urandom_range(255, 1));
            build_expected(1);
            run_frame(1, (pass == 0) ? 100 : 40, -1, -1, done);
            checks++;
            if (!done) begin errors++; $display("FAIL small_frame pass%0d done: no Done within %0d cycles", pass, BUDGET); end
            checks++;
            if (got_data.size() != exp_data.size()) begin
                errors++;
                $display("FAIL small_frame pass%0d byte_count: got %0d, required %0d", pass, got_data.size(), exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL small_frame pass%0d byte[%0d]: got %h last=%b, required %h last=%b",
                             pass, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                end
            end
            checks++;
            if (addr_log.size() != npix(1) || (addr_log.size() > 0 && addr_log[addr_log.size() - 1] != npix(1) - 1)) begin
                errors++;
                $display("FAIL small_frame pass%0d reads: %0d reads, required %0d ending at %0d",
                         pass, addr_log.size(), npix(1), npix(1) - 1);
            end
            @(negedge Clk);
            o = observe(1);
            checks++;
            if (o.done !== 1'b0 || o.busy !== 1'b0) begin
                errors++;
                $display("FAIL small_frame pass%0d after_done: done=%b busy=%b, required 0 0", pass, o.done, o.busy);
            end
        end
    endtask

    task automatic test_go_while_busy();
        bit done;
        bit spurious;
        obs_t o;
        for (int k = 0; k < 256; k++) mem[0][k] = 8'($urandom_range(1) * 255);
        build_expected(0);
        run_frame(0, 100, -1, 5, done);
        checks++;
        if (!done) begin errors++; $display("FAIL go_while_busy done: no Done within %0d cycles", BUDGET); end
        checks++;
        if (got_data.size() != exp_data.size() || addr_log.size() != npix(0)) begin
            errors++;
            $display("FAIL go_while_busy frame_len: got %0d bytes %0d reads, required %0d bytes %0d reads",
                     got_data.size(), addr_log.size(), exp_data.size(), npix(0));
        end
        spurious = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            o = observe(0);
            if (o.valid || o.busy || o.ren) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL go_while_busy restart: activity after Done, required idle"); end
    endtask

    task automatic test_reset_mid_frame();
        bit done;
        obs_t o;
        int bad_at;
        for (int k = 0; k < 256; k++) mem[0][k] = 8'($urandom_range(1) * $urandom_range(255, 1));
        run_frame(0, 100, 10, -1, done);
        #1 Rst = 1'b1;
        #1;
        o = observe(0);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_mid_frame async: outputs %h, required all zero", o); end
        @(negedge Clk);
        Rst = 1'b0;
        build_expected(0);
        run_frame(0, 80, -1, -1, done);
        checks++;
        if (!done) begin errors++; $display("FAIL reset_mid_frame done: no Done within %0d cycles", BUDGET); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL reset_mid_frame byte_count: got %0d, required %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL reset_mid_frame byte[%0d]: got %h last=%b, required %h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        bad_at = -1;
        for (int i = 0; i < addr_log.size(); i++) if (bad_at < 0 && addr_log[i] != i) bad_at = i;
        checks++;
        if (addr_log.size() != npix(0) || bad_at >= 0) begin
            errors++;
            $display("FAIL reset_mid_frame addr_seq: %0d reads, first wrong index %0d, required %0d reads from 0",
                     addr_log.size(), bad_at, npix(0));
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_backpressure();
        test_random_data();
        test_small_frame();
        test_go_while_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
